// File: rtl/spawn_pkg.sv
// Shared types and constants for the sprite spawn scheduler.
package spawn_pkg;
  localparam int unsigned X_W          = 9;
  localparam int unsigned TYPE_W       = 2;
  localparam int unsigned GAP_W        = 8;
  localparam int unsigned REJ_W        = 4;
  localparam int unsigned DROP_W       = 8;
  localparam int unsigned PEND_W       = 3;
  localparam int unsigned REJECT_LIMIT = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2
  } state_t;

  typedef struct packed {
    logic [X_W-1:0]    x;
    logic [TYPE_W-1:0] sp_type;
  } spawn_t;
endpackage

// File: rtl/spawn_fifo.sv
// Pending-spawn FIFO; no pass-through, head reads zero when empty.
module spawn_fifo
  import spawn_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  spawn_t        i_din,
  input  logic          i_pop,
  output spawn_t        o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  spawn_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_count;
  logic            w_wr_en;
  logic            w_rd_en;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = o_empty ? '0 : r_mem[r_rd];

  // A push into a full FIFO only lands when the head leaves the same cycle.
  assign w_wr_en = i_push && (!o_full || i_pop);
  assign w_rd_en = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + AW'(1);
      if (w_rd_en) r_rd <= r_rd + AW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/spawn_sched.sv
// Frame-paced sprite spawn scheduler: gap timer, column sampling with
// bounded rejection, pending FIFO and drop counter.
module spawn_sched
  import spawn_pkg::*;
#(
  parameter logic [8:0]  MAX_X   = 9'd480,
  parameter logic [7:0]  MIN_GAP = 8'd30,
  parameter int unsigned DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_frame_tick,
  input  logic       i_enable,
  input  logic [8:0] i_rand_val,
  output logic       o_spawn_valid,
  input  logic       i_spawn_ready,
  output logic [8:0] o_spawn_x,
  output logic [1:0] o_spawn_type,
  output logic [2:0] o_pending,
  output logic [7:0] o_drop_cnt
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_t             r_state;
  logic [GAP_W-1:0]   r_gap;
  logic [REJ_W-1:0]   r_rej;
  logic [DROP_W-1:0]  r_drop;

  logic               w_in_range;
  logic               w_forced;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [CW-1:0]      w_count;
  logic [GAP_W-1:0]   w_gap_reload;
  spawn_t             w_spawn;
  spawn_t             w_head;

  assign w_in_range   = (i_rand_val < MAX_X);
  assign w_forced     = (r_rej == REJ_W'(REJECT_LIMIT));
  assign w_push       = (r_state == S_SAMPLE) && i_enable && (w_in_range || w_forced);
  assign w_pop        = o_spawn_valid && i_spawn_ready;
  assign w_gap_reload = MIN_GAP + GAP_W'(i_rand_val[3:0]);

  // Out-of-range samples that are forced fold back into the legal column span.
  always_comb begin
    w_spawn         = '0;
    w_spawn.x       = w_in_range ? i_rand_val : (i_rand_val - MAX_X);
    w_spawn.sp_type = i_rand_val[8:7];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_gap   <= '0;
      r_rej   <= '0;
    end else if (!i_enable) begin
      r_state <= S_IDLE;
      r_rej   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_gap   <= MIN_GAP;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_frame_tick) begin
            if (r_gap <= GAP_W'(1)) begin
              r_gap   <= '0;
              r_state <= S_SAMPLE;
            end else begin
              r_gap <= r_gap - GAP_W'(1);
            end
          end
        end
        S_SAMPLE: begin
          if (w_push) begin
            r_gap   <= w_gap_reload;
            r_rej   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_rej <= r_rej + REJ_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating count of pushes lost to a full FIFO.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_drop <= '0;
    end else if (w_push && w_full && !w_pop && (r_drop != '1)) begin
      r_drop <= r_drop + DROP_W'(1);
    end
  end

  spawn_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_din   (w_spawn),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign o_pending     = PEND_W'(w_count);
  assign o_spawn_valid = !w_empty;
  assign o_spawn_x     = w_head.x;
  assign o_spawn_type  = w_head.sp_type;
  assign o_drop_cnt    = r_drop;
endmodule

// File: tb/tb_spawn_sched.sv
// Directed bench for spawn_sched: vector table plus hand-written FIFO,
// reset and saturation sequences (MIN_GAP overridden to 2).
module tb_spawn_sched;
  import spawn_pkg::*;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       en;
  logic [8:0] rnd;
  logic       rdy;
  logic       valid;
  logic [8:0] sx;
  logic [1:0] stype;
  logic [2:0] pend;
  logic [7:0] drop;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic       tick;
    logic       rdy;
    logic [8:0] rnd;
    int         v;
    int         x;
    int         t;
    int         p;
    int         st;
  } vec_t;

  vec_t vecs[$];
  int   vals[6];

  spawn_sched #(.MAX_X(9'd480), .MIN_GAP(8'd2), .DEPTH(4)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_frame_tick  (tick),
    .i_enable      (en),
    .i_rand_val    (rnd),
    .o_spawn_valid (valid),
    .i_spawn_ready (rdy),
    .o_spawn_x     (sx),
    .o_spawn_type  (stype),
    .o_pending     (pend),
    .o_drop_cnt    (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int v, input int x, input int t,
                            input int p, input int d);
    check({tag, ".valid"}, int'(valid), v);
    check({tag, ".x"}, int'(sx), x);
    check({tag, ".type"}, int'(stype), t);
    check({tag, ".pending"}, int'(pend), p);
    check({tag, ".drop"}, int'(drop), d);
  endtask

  task automatic add(input logic e, input logic tk, input logic rd, input logic [8:0] r,
                     input int v, input int x, input int t, input int p, input int st);
    vec_t row;
    row.en = e; row.tick = tk; row.rdy = rd; row.rnd = r;
    row.v = v; row.x = x; row.t = t; row.p = p; row.st = st;
    vecs.push_back(row);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; tick = 1'b0; rdy = 1'b0; rnd = '0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; tick = 1'b0; rdy = 1'b0; rnd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 0);
    check("reset.state", int'(dut.r_state), int'(S_IDLE));
    check("reset.gap", int'(dut.r_gap), 0);
    check("reset.rej", int'(dut.r_rej), 0);

    // Accept, reject x3 then accept, then 8 rejects and a forced 9th sample.
    add(1, 0, 0, 9'd100, 0, 0, 0, 0, 1);
    add(1, 1, 0, 9'd100, 0, 0, 0, 0, 1);
    add(1, 1, 0, 9'd100, 0, 0, 0, 0, 2);
    add(1, 0, 0, 9'd100, 1, 100, 0, 1, 1);
    for (int i = 0; i < 5; i++) add(1, 1, 0, 9'd500, 1, 100, 0, 1, 1);
    add(1, 1, 0, 9'd500, 1, 100, 0, 1, 2);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 9'd500, 1, 100, 0, 1, 2);
    add(1, 1, 1, 9'd37, 1, 37, 0, 1, 1);
    for (int i = 0; i < 6; i++) add(1, 1, 0, 9'd500, 1, 37, 0, 1, 1);
    add(1, 1, 0, 9'd500, 1, 37, 0, 1, 2);
    for (int i = 0; i < 8; i++) add(1, 1, 0, 9'd500, 1, 37, 0, 1, 2);
    add(1, 1, 1, 9'd500, 1, 20, 3, 1, 1);
    add(1, 0, 1, 9'd500, 0, 0, 0, 0, 1);
    add(0, 0, 0, 9'd500, 0, 0, 0, 0, 0);

    rst = 1'b0;
    foreach (vecs[i]) begin
      en = vecs[i].en; tick = vecs[i].tick; rdy = vecs[i].rdy; rnd = vecs[i].rnd;
      cyc();
      check_outs($sformatf("vec%0d", i), vecs[i].v, vecs[i].x, vecs[i].t, vecs[i].p, 0);
      check($sformatf("vec%0d.state", i), int'(dut.r_state), vecs[i].st);
      if (i == 3) check("vec3.gap_reload", int'(dut.r_gap), 6);
    end

    // Fill with ready low: 5 accepts -> 4 held, 1 dropped; then pop+push on full.
    vals = '{16, 272, 400, 144, 80, 208};
    do_reset();
    for (int n = 1; n <= 19; n++) begin
      en = 1'b1; tick = 1'b1; rdy = (n == 19);
      rnd = 9'(vals[(n <= 4) ? 0 : (n - 2) / 3]);
      cyc();
      if (n == 16) check_outs("full", 1, 16, 0, 4, 1);
    end
    check_outs("popush", 1, 272, 2, 4, 1);
    en = 1'b0; tick = 1'b0; rdy = 1'b1;
    cyc(); check_outs("drain1", 1, 400, 3, 3, 1);
    check("drain1.state", int'(dut.r_state), int'(S_IDLE));
    cyc(); check_outs("drain2", 1, 144, 1, 2, 1);
    cyc(); check_outs("drain3", 1, 208, 1, 1, 1);
    cyc(); check_outs("drain4", 0, 0, 0, 0, 1);

    // Reset mid-WAIT with two pending and a pop requested in the same cycle.
    do_reset();
    for (int n = 1; n <= 8; n++) begin
      en = 1'b1; tick = 1'b1; rdy = (n == 8); rnd = 9'd16; rst = (n == 8);
      cyc();
      if (n == 7) begin
        check("midwait.pending", int'(pend), 2);
        check("midwait.state", int'(dut.r_state), int'(S_WAIT));
      end
    end
    check_outs("rst_mid", 0, 0, 0, 0, 0);
    check("rst_mid.state", int'(dut.r_state), int'(S_IDLE));
    check("rst_mid.gap", int'(dut.r_gap), 0);

    // Drop enable while rejecting in SAMPLE: IDLE, reject count cleared, FIFO kept.
    rst = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      en = 1'b1; tick = 1'b1; rdy = 1'b0; rnd = (n <= 4) ? 9'd16 : 9'd500;
      cyc();
    end
    check("sample.state", int'(dut.r_state), int'(S_SAMPLE));
    check("sample.rej", int'(dut.r_rej), 1);
    en = 1'b0;
    cyc();
    check("dis.state", int'(dut.r_state), int'(S_IDLE));
    check("dis.rej", int'(dut.r_rej), 0);
    check_outs("dis", 1, 16, 0, 1, 0);

    // Long run with ready low: drop counter must saturate.
    do_reset();
    en = 1'b1; tick = 1'b1; rdy = 1'b0; rnd = 9'd16;
    repeat (800) cyc();
    check_outs("sat", 1, 16, 0, 4, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spawn_sched.md
SPAWN_SCHED -- requirements
Module: spawn_sched

Interface
REQ-001 SHALL have parameter MAX_X, default 9'd480: exclusive upper bound of spawn column; legal range 256..511.
REQ-002 SHALL have parameter MIN_GAP, default 8'd30: minimum frames between spawns; legal range 1..239.
REQ-003 SHALL have parameter DEPTH, default 4: pending-spawn FIFO depth, power of two.
REQ-004 Clk  in  1  system clock; single clock domain.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 frame_tick  in  1  one-Clk pulse per video frame.
REQ-007 enable  in  1  spawning allowed when high.
REQ-008 rand_val  in  9  output of the 9-bit LFSR; advances every Clk.
REQ-009 spawn_valid  out  1  FIFO head holds a spawn.
REQ-010 spawn_ready  in  1  sprite engine accepts head.
REQ-011 spawn_x  out  9  head column.
REQ-012 spawn_type  out  2  head sprite type.
REQ-013 pending  out  3  FIFO occupancy, 0..DEPTH.
REQ-014 drop_cnt  out  8  count of spawns dropped on full FIFO.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, SAMPLE.
REQ-016 IDLE: when enable=1, load gap counter with MIN_GAP and enter WAIT next cycle.
REQ-017 WAIT: each frame_tick decrements gap; the tick taking gap to 0 moves the FSM to SAMPLE on the next cycle.
REQ-018 SAMPLE accept: if rand_val < MAX_X, push {x=rand_val, type=rand_val[8:7]}, reload gap = MIN_GAP + rand_val[3:0], go to WAIT.
REQ-019 SAMPLE reject: if rand_val >= MAX_X, stay in SAMPLE, increment the reject counter, and resample next cycle.
REQ-020 After 8 consecutive rejects, the 9th sample SHALL be forced: x = rand_val - MAX_X, type = rand_val[8:7]; the reject counter clears on any push.
REQ-021 enable=0 in any state SHALL force IDLE next cycle and clear the reject counter; FIFO contents are retained and keep draining.
REQ-022 Push to a full FIFO without a same-cycle pop SHALL be discarded; drop_cnt increments and saturates at 255.
REQ-023 A pop occurs when spawn_valid && spawn_ready; a simultaneous push and pop on a full FIFO SHALL both succeed.
REQ-024 Pushes to an empty FIFO SHALL have no pass-through; spawn_valid asserts the cycle after the accept.
REQ-025 spawn_x and spawn_type SHALL hold stable while spawn_valid && !spawn_ready; FIFO order is FIFO.
REQ-026 spawn_valid SHALL equal (pending != 0); outputs read 0 when the FIFO is empty.
REQ-027 frame_tick outside WAIT SHALL be ignored.

Reset
REQ-028 Reset SHALL set FSM=IDLE, gap=0, reject counter=0, FIFO empty, pending=0, drop_cnt=0, spawn_valid=0, spawn_x=0, spawn_type=0.
REQ-029 Reset SHALL take priority over all other inputs, including mid-SAMPLE or during a pop.

Structure
REQ-030 Package spawn_pkg SHALL hold the state enum, the spawn_t struct {x[8:0], type[1:0]}, and the REJECT_LIMIT=8 constant.
REQ-031 The FIFO SHALL be a separate sub-module spawn_fifo (parameter DEPTH, push/pop/full/empty/count); the FSM and counters live in spawn_sched.

Verification
REQ-032 Defaults except MIN_GAP=2; rand_val=100 held; enable=1; 2 ticks -> push x=100, type=0; spawn_valid the next cycle; gap reloaded to 6.
REQ-033 In SAMPLE, rand_val=500,500,500,37 -> three rejects, then push x=37, type=0.
REQ-034 rand_val=500 held through 9 samples -> forced push x=20, type=3 on the 9th sample.
REQ-035 spawn_ready=0, 5 accepts -> pending=4, drop_cnt=1; then spawn_ready=1 -> first four entries drained in order; pop+push while full -> pending stays 4, drop_cnt unchanged.
REQ-036 Reset asserted mid-WAIT with pending=2 -> next cycle FSM=IDLE, pending=0, spawn_valid=0; enable toggled low in SAMPLE -> IDLE, FIFO retained.
